// File: rtl/addr4u_pkg.sv
// Shared definitions for the addr4u fault monitor.
//   - operand and sum widths of the 4-bit unsigned adder under test
//   - FSM state encoding (IDLE / WAIT / OUT)
//   - sat_inc: saturating increment for counters up to 32 bits wide
package addr4u_pkg;

  localparam int OPND_W = 4;
  localparam int SUM_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // The counter value and its all-ones limit are passed zero-extended to
  // 32 bits, so one function serves any counter width from 1 to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/addr4u_golden.sv
// Exact reference adder: 4-bit + 4-bit unsigned -> 5-bit sum.
// Purely combinational; the carry-out lands in sum_o[4], so no overflow.
// Ports:
//   a_i   [3:0]  operand A
//   b_i   [3:0]  operand B
//   sum_o [4:0]  exact sum
module addr4u_golden
  import addr4u_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  output logic [SUM_W-1:0]  sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/addr4u_fault_monitor.sv
// Harness stage around an external combinational 4-bit adder. Operands are
// accepted over a valid/ready handshake, registered onto dut_a/dut_b, given
// SETTLE cycles to propagate, and the returned dut_sum is sampled, compared
// with an exact golden sum and forwarded with an error flag. Saturating
// counters record completed samples and mismatches.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends combinationally on valid on either side.
//
// Parameters:
//   SETTLE  1..15  cycles dut_sum is allowed to settle after dut_a/dut_b change
//   CNT_W   1..32  width of op_count / err_count
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake; in_a, in_b operands
//   dut_a, dut_b             registered operands driving the adder under test
//   dut_sum                  adder result (multicycle path of SETTLE cycles)
//   out_valid/out_ready      result handshake; out_sum, out_err result payload
//   clear                    synchronous zeroing of both counters
//   op_count, err_count      saturating sample / mismatch counters
//   dbg_state                current FSM state (debug observation only)
module addr4u_fault_monitor
  import addr4u_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  output logic [OPND_W-1:0] dut_a,
  output logic [OPND_W-1:0] dut_b,
  input  logic [SUM_W-1:0]  dut_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_err,
  input  logic              clear,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state_q, state_d;
  logic [OPND_W-1:0] dut_a_q, dut_a_d;
  logic [OPND_W-1:0] dut_b_q, dut_b_d;
  logic [SUM_W-1:0]  gold_q, gold_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  opc_q, opc_d;
  logic [CNT_W-1:0]  errc_q, errc_d;

  logic [SUM_W-1:0]  gold_sum;
  logic              sample;
  logic              mismatch;

  // The golden sum is computed from the incoming operands and latched at
  // accept, so the compare in WAIT uses a register and not the live inputs.
  addr4u_golden u_golden (
    .a_i   (in_a),
    .b_i   (in_b),
    .sum_o (gold_sum)
  );

  assign mismatch = (dut_sum != gold_q);

  always_comb begin
    state_d = state_q;
    dut_a_d = dut_a_q;
    dut_b_d = dut_b_q;
    gold_d  = gold_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    err_d   = err_q;
    sample  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dut_a_d = in_a;
          dut_b_d = in_b;
          gold_d  = gold_sum;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sum_d   = dut_sum;
          err_d   = mismatch;
          sample  = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        // Only the output handshake leaves OUT; in_valid is ignored here.
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear takes priority over a coinciding sample; it never touches the FSM.
  always_comb begin
    opc_d  = opc_q;
    errc_d = errc_q;
    if (clear) begin
      opc_d  = '0;
      errc_d = '0;
    end else if (sample) begin
      opc_d = CNT_W'(sat_inc(32'(opc_q), 32'(CNT_MAX)));
      if (mismatch) errc_d = CNT_W'(sat_inc(32'(errc_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dut_a_q <= '0;
      dut_b_q <= '0;
      gold_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      opc_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      dut_a_q <= dut_a_d;
      dut_b_q <= dut_b_d;
      gold_q  <= gold_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      opc_q   <= opc_d;
      errc_q  <= errc_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign out_sum   = sum_q;
  assign out_err   = err_q;
  assign op_count  = opc_q;
  assign err_count = errc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addr4u_fault_monitor.sv
// Bench for addr4u_fault_monitor. Two instances: u0 (SETTLE=1, CNT_W=4) and
// u1 (SETTLE=3, CNT_W=16). Each drives its own behavioural adder model on
// dut_sum, which can be forced to a fixed value to inject faults. Expected
// results (sum, err flag, both counters) are pushed at issue time and
// compared by a negedge monitor whenever out_valid is high.
module tb_addr4u_fault_monitor;

  localparam int S0 = 1;
  localparam int S1 = 3;
  localparam int MAX0 = 15;
  localparam int MAX1 = 65535;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv[2], ordy[2], clr[2], fen[2];
  logic [3:0] ia[2], ib[2];
  logic [4:0] fval[2];
  logic       irdy[2], ov[2], oe[2];
  logic [3:0] da[2], db[2];
  logic [4:0] ds[2], os[2];
  logic [3:0]  opc0, ec0;
  logic [15:0] opc1, ec1;
  logic [1:0]  dbg0, dbg1;

  // External adder models, optionally forced to a faulty value.
  assign ds[0] = fen[0] ? fval[0] : 5'(da[0]) + 5'(db[0]);
  assign ds[1] = fen[1] ? fval[1] : 5'(da[1]) + 5'(db[1]);

  addr4u_fault_monitor #(.SETTLE(S0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(ia[0]), .in_b(ib[0]), .dut_a(da[0]), .dut_b(db[0]),
    .dut_sum(ds[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os[0]), .out_err(oe[0]), .clear(clr[0]),
    .op_count(opc0), .err_count(ec0), .dbg_state(dbg0)
  );

  addr4u_fault_monitor #(.SETTLE(S1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(ia[1]), .in_b(ib[1]), .dut_a(da[1]), .dut_b(db[1]),
    .dut_sum(ds[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(os[1]), .out_err(oe[1]), .clear(clr[1]),
    .op_count(opc1), .err_count(ec1), .dbg_state(dbg1)
  );

  // scoreboard: {sum[4:0], err, op_count[15:0], err_count[15:0]}
  logic [37:0] exp_q0[$];
  logic [37:0] exp_q1[$];
  int mop[2];
  int merr[2];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_opc(input int i);
    return (i == 0) ? 16'(opc0) : opc1;
  endfunction

  function automatic logic [15:0] get_ec(input int i);
    return (i == 0) ? 16'(ec0) : ec1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor
  task automatic mon(input int i);
    logic [37:0] e;
    int sz;
    sz = (i == 0) ? exp_q0.size() : exp_q1.size();
    if (ov[i]) begin
      if (sz == 0) begin
        chk("unexpected_out_valid", 40'(ov[i]), 40'd0);
      end else begin
        e = (i == 0) ? exp_q0[0] : exp_q1[0];
        chk("out_sum", 40'(os[i]), 40'(e[37:33]));
        chk("out_err", 40'(oe[i]), 40'(e[32]));
        chk("op_count", 40'(get_opc(i)), 40'(e[31:16]));
        chk("err_count", 40'(get_ec(i)), 40'(e[15:0]));
        if (ordy[i]) begin
          if (i == 0) void'(exp_q0.pop_front());
          else        void'(exp_q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  // driver tasks
  task automatic clear_counters(input int i);
    clr[i] = 1'b1;
    tick();
    clr[i] = 1'b0;
    mop[i] = 0;
    merr[i] = 0;
    chk("clear_op_count", 40'(get_opc(i)), 40'd0);
    chk("clear_err_count", 40'(get_ec(i)), 40'd0);
  endtask

  task automatic send(input int i, input int a, input int b, input bit force_en,
                      input int force_v, input bit clr_s, input int hold);
    int t = 0;
    int settle = (i == 0) ? S0 : S1;
    int mx = (i == 0) ? MAX0 : MAX1;
    int good;
    int msum;
    logic [37:0] e;
    while (!irdy[i] && t < 50) begin
      tick();
      t++;
    end
    if (!irdy[i]) begin
      chk("in_ready_wait", 40'(irdy[i]), 40'd1);
      return;
    end
    good = a + b;
    msum = force_en ? force_v : good;
    if (clr_s) begin
      mop[i] = 0;
      merr[i] = 0;
    end else begin
      mop[i] = sat(mop[i], mx);
      if (msum != good) merr[i] = sat(merr[i], mx);
    end
    e = {5'(msum), (msum != good), 16'(mop[i]), 16'(merr[i])};
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);

    iv[i] = 1'b1;
    ia[i] = 4'(a);
    ib[i] = 4'(b);
    fen[i] = force_en;
    fval[i] = 5'(force_v);
    tick();
    iv[i] = 1'b0;
    chk("dut_a_latched", 40'(da[i]), 40'(a));
    chk("dut_b_latched", 40'(db[i]), 40'(b));
    for (int c = 1; c <= settle; c++) begin
      chk("no_early_valid", 40'(ov[i]), 40'd0);
      if (c == settle && clr_s) clr[i] = 1'b1;
      tick();
    end
    chk("valid_latency", 40'(ov[i]), 40'd1);
    clr[i] = 1'b0;

    // New operands offered while the result is pending must not be taken.
    iv[i] = 1'b1;
    ia[i] = ~4'(a);
    ib[i] = ~4'(b);
    if (hold > 0) begin
      ordy[i] = 1'b0;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("in_ready_blocked", 40'(irdy[i]), 40'd0);
        chk("out_valid_held", 40'(ov[i]), 40'd1);
        chk("dut_a_stable", 40'(da[i]), 40'(a));
      end
      ordy[i] = 1'b1;
    end
    tick();
    iv[i] = 1'b0;
    chk("idle_after_ready", 40'(irdy[i]), 40'd1);
    chk("valid_dropped", 40'(ov[i]), 40'd0);
    chk("dut_a_not_taken_in_out", 40'(da[i]), 40'(a));
    chk("dut_b_not_taken_in_out", 40'(db[i]), 40'(b));
  endtask

  initial begin
    int a;
    int b;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; clr[i] = 1'b0; fen[i] = 1'b0;
      ia[i] = '0; ib[i] = '0; fval[i] = '0;
      mop[i] = 0; merr[i] = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 40'(irdy[i]), 40'd1);
      chk("rst_out_valid", 40'(ov[i]), 40'd0);
      chk("rst_dut_a", 40'(da[i]), 40'd0);
      chk("rst_dut_b", 40'(db[i]), 40'd0);
      chk("rst_out_sum", 40'(os[i]), 40'd0);
      chk("rst_out_err", 40'(oe[i]), 40'd0);
      chk("rst_op_count", 40'(get_opc(i)), 40'd0);
      chk("rst_err_count", 40'(get_ec(i)), 40'd0);
    end
    rst = 1'b0;
    tick();

    // Reset in the middle of WAIT drops the transaction.
    iv[1] = 1'b1; ia[1] = 4'd5; ib[1] = 4'd6;
    tick();
    iv[1] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midwait_rst_valid", 40'(ov[1]), 40'd0);
    chk("midwait_rst_ready", 40'(irdy[1]), 40'd1);
    chk("midwait_rst_dut_a", 40'(da[1]), 40'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < S1 + 2; k++) begin
      tick();
      chk("midwait_no_valid", 40'(ov[1]), 40'd0);
    end
    chk("midwait_op_count", 40'(opc1), 40'd0);
    chk("midwait_err_count", 40'(ec1), 40'd0);

    // u0, SETTLE=1
    send(0, 9, 7, 1'b0, 0, 1'b0, 0);
    clear_counters(0);
    send(0, 9, 7, 1'b1, 15, 1'b0, 0);
    send(0, 3, 4, 1'b0, 0, 1'b0, 5);
    for (int k = 0; k < 12; k++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      send(0, a, b, ($urandom_range(0, 3) == 0), $urandom_range(0, 31), 1'b0,
           $urandom_range(0, 2));
    end
    // 20 forced mismatches: both counters pin at 15.
    clear_counters(0);
    for (int k = 0; k < 20; k++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      send(0, a, b, 1'b1, (a + b) ^ 1, 1'b0, 0);
    end
    chk("sat_op_count", 40'(opc0), 40'd15);
    chk("sat_err_count", 40'(ec0), 40'd15);

    // u1, SETTLE=3
    send(1, 15, 15, 1'b0, 0, 1'b0, 0);
    send(1, 15, 15, 1'b0, 0, 1'b1, 0);
    chk("clear_on_sample_op", 40'(opc1), 40'd0);
    chk("clear_on_sample_err", 40'(ec1), 40'd0);
    for (int k = 0; k < 10; k++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      send(1, a, b, ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
           ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    tick();
    tick();
    chk("queue0_drained", 40'(exp_q0.size()), 40'd0);
    chk("queue1_drained", 40'(exp_q1.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
